result_bcd_converter: RTL and testbench

- Sits directly downstream of the divider control FSM and datapath.
- Captures the divider result when the FSM's `ready` status pulses, then converts it serially from binary to packed BCD (shift-and-add-3, one bit per clock).
- Drives the seven-segment display decoder with the digits. A divide-by-zero `error` is shown as a fixed error code.

---
 rtl/result_bcd_converter.sv | 211 +++++++++++++++++++++
 tb/tb_result_bcd_converter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// ----------------------------------------------------------------------------
// result_bcd_converter
//
// Captures the divider result when the divider FSM pulses `ready`. It then
// converts the result serially from binary to packed BCD using
// shift-and-add-3, one bit per clock. The digits drive the seven-segment
// decoder. A divide-by-zero result is shown as 4'hE in every digit.
//
// Optional build macro:
//   RESULT_BCD_BLANK_EN - when defined, leading zero digits above digit 0 are
//                         replaced by 4'hF (display blank code) on completion.
//                         The error code is never blanked. When undefined, no
//                         blanking logic exists.
//
// Parameters:
//   WIDTH   - bit width of the binary result (default 8)
//   DIGITS  - number of BCD digits (default 3); must satisfy
//             10^DIGITS > 2^WIDTH - 1
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   ready_in  in   result-ready pulse from the divider FSM
//   error_in  in   divide-by-zero flag, qualified by ready_in
//   value_in  in   [WIDTH-1:0] binary result, qualified by ready_in
//   bcd_out   out  [4*DIGITS-1:0] packed BCD, digit 0 (units) in [3:0]
//   bcd_valid out  bcd_out holds a finished conversion or the error code
//   busy      out  conversion in progress; captures are refused
//   err_out   out  displayed result is the error code
// ----------------------------------------------------------------------------
module result_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready_in,
    input  logic                  error_in,
    input  logic [WIDTH-1:0]      value_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  err_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [BW-1:0] ERR_CODE = {DIGITS{4'hE}};

    // ------------------------------------------------------------------------
    // Configuration check: the digit count must hold the largest input value.
    // ------------------------------------------------------------------------
    function automatic logic [127:0] pow10(input int n);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 128'd10;
        end
        return p;
    endfunction

    localparam logic [127:0] MAX_VALUE = (128'd1 << WIDTH) - 128'd1;

    if (pow10(DIGITS) <= MAX_VALUE) begin : g_bad_config
        $error("result_bcd_converter: DIGITS too small for WIDTH");
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // Add 3 to every 4-bit digit that is 5 or more, before it is shifted.
    // After the shift the digit then carries correctly into the next decade.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] acc);
        logic [BW-1:0] res;
        logic [3:0]    nib;
        res = {BW{1'b0}};
        for (int d = 0; d < DIGITS; d++) begin
            nib = acc[4*d +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end else begin
                nib = nib;
            end
            res[4*d +: 4] = nib;
        end
        return res;
    endfunction

`ifdef RESULT_BCD_BLANK_EN
    // Replace leading zero digits with 4'hF. The scan runs from the most
    // significant digit down and stops at the first non-zero digit. Digit 0
    // is excluded, so a zero result still shows "0".
    function automatic logic [BW-1:0] blank_leading(input logic [BW-1:0] acc);
        logic [BW-1:0] res;
        logic          leading;
        res     = acc;
        leading = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (leading && (acc[4*d +: 4] == 4'h0)) begin
                res[4*d +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
        return res;
    endfunction
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   bin_r;
    logic [BW-1:0]      acc_r;
    logic [CW-1:0]      cnt_r;

    logic [BW-1:0]      acc_adj_s;
    logic [BW-1:0]      acc_next_s;
    logic [WIDTH-1:0]   bin_next_s;
    logic [BW-1:0]      final_s;
    logic               last_step_s;

    // One conversion step: add-3 correction, then shift {acc, bin} left by one.
    always_comb begin
        acc_adj_s   = add3_digits(acc_r);
        acc_next_s  = {acc_adj_s[BW-2:0], bin_r[WIDTH-1]};
        bin_next_s  = {bin_r[WIDTH-2:0], 1'b0};
`ifdef RESULT_BCD_BLANK_EN
        final_s     = blank_leading(acc_next_s);
`else
        final_s     = acc_next_s;
`endif
        if (cnt_r == CNT_ONE) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
    end

    // Control FSM with registered outputs. Captures happen only in IDLE.
    // In CONVERT, ready_in is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            bin_r     <= {WIDTH{1'b0}};
            acc_r     <= {BW{1'b0}};
            cnt_r     <= CNT_ZERO;
            bcd_out   <= {BW{1'b0}};
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ready_in && error_in) begin
                        // Divide-by-zero: show the error code immediately.
                        bcd_out   <= ERR_CODE;
                        bcd_valid <= 1'b1;
                        err_out   <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else if (ready_in) begin
                        // Start a conversion. bcd_out is left untouched so
                        // the display does not flicker while converting.
                        bin_r     <= value_in;
                        acc_r     <= {BW{1'b0}};
                        cnt_r     <= CNT_LOAD;
                        bcd_valid <= 1'b0;
                        err_out   <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= CONVERT;
                    end else begin
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                CONVERT: begin
                    acc_r <= acc_next_s;
                    bin_r <= bin_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (last_step_s) begin
                        bcd_out   <= final_s;
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        busy      <= 1'b1;
                        state_r   <= CONVERT;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// ----------------------------------------------------------------------------
// Testbench for result_bcd_converter.
//
// The driver issues captures and pushes the expected display into a
// scoreboard queue. The expected display is worked out with decimal
// arithmetic. A monitor pops an entry whenever the DUT presents a new result,
// then compares the digits, the error flag and the latency.
// ----------------------------------------------------------------------------
module tb_result_bcd_converter;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int BW = 4 * D;

    logic            clk;
    logic            reset;
    logic            ready_in;
    logic            error_in;
    logic [W-1:0]    value_in;
    logic [BW-1:0]   bcd_out;
    logic            bcd_valid;
    logic            busy;
    logic            err_out;

    result_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready_in  (ready_in),
        .error_in  (error_in),
        .value_in  (value_in),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .err_out   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [BW-1:0] bcd;
        logic          err;
        int            issue;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] shown;      // what the display should currently hold
    logic          last_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits from plain division, optional leading blanks.
    function automatic logic [BW-1:0] ref_bcd(input int v);
        logic [BW-1:0] r;
        int            p;
        int            dig;
        bit            seen;
        r    = '0;
        seen = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            dig = (v / p) % 10;
            if (dig != 0) seen = 1'b1;
`ifdef RESULT_BCD_BLANK_EN
            if (!seen && i > 0) r[4*i +: 4] = 4'hF;
            else                r[4*i +: 4] = 4'(dig);
`else
            r[4*i +: 4] = 4'(dig);
`endif
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
        end
    endtask

    // Monitor: a new result is bcd_valid rising, or err_out rising while valid.
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;
    exp_t m;
    always @(negedge clk) begin
        if (!reset) begin
            if (bcd_valid && (!prev_valid || (err_out && !prev_err))) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got bcd=%h err=%b, required no output", bcd_out, err_out);
                end else begin
                    m = sb.pop_front();
                    chk("mon_bcd", 32'(bcd_out), 32'(m.bcd));
                    chk("mon_err", 32'(err_out), 32'(m.err));
                    chk("mon_latency", 32'(cyc - m.issue), 32'(m.lat));
                end
            end
        end
        prev_valid = bcd_valid;
        prev_err   = err_out;
    end

    // Issue one capture. inject: -1 none, -2 random ignored pulses,
    // >=0 pulse value 77 at that conversion cycle. stop_at >= 0 returns
    // early after that many busy cycles, leaving the conversion running.
    task automatic capture(input int v, input bit e, input int inject, input int stop_at);
        int   cnt;
        exp_t x;
        @(negedge clk);
        ready_in = 1'b1;
        error_in = e;
        value_in = W'(v);
        x.issue  = cyc + 1;
        if (e) begin
            x.bcd = {D{4'hE}};
            x.err = 1'b1;
            x.lat = 0;
        end else begin
            x.bcd = ref_bcd(v);
            x.err = 1'b0;
            x.lat = W;
        end
        sb.push_back(x);
        @(negedge clk);
        ready_in = 1'b0;
        error_in = 1'b0;
        if (e) begin
            chk("err_no_busy", 32'(busy), 32'd0);
            shown    = x.bcd;
            last_err = 1'b1;
        end else begin
            chk("cap_clears_valid", 32'(bcd_valid), 32'd0);
            chk("cap_clears_err", 32'(err_out), 32'd0);
            chk("cap_holds_display", 32'(bcd_out), 32'(shown));
            cnt = 0;
            while (busy && cnt < 40) begin
                if (cnt == stop_at) return;
                if ((inject == -2 && $urandom_range(0, 3) == 0) || (inject == cnt)) begin
                    ready_in = 1'b1;
                    error_in = ($urandom_range(0, 3) == 0);
                    value_in = (inject >= 0) ? W'(77) : W'($urandom);
                end
                cnt++;
                @(negedge clk);
                ready_in = 1'b0;
                error_in = 1'b0;
            end
            chk("busy_cycles", 32'(cnt), 32'(W));
            shown    = x.bcd;
            last_err = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  v;
        bit  e;
        reset    = 1'b1;
        ready_in = 1'b0;
        error_in = 1'b0;
        value_in = '0;
        shown    = '0;
        last_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_valid", 32'(bcd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        reset = 1'b0;

        // Directed patterns and boundaries
        capture(255, 1'b0, -1, -1);
        capture(0,   1'b0, -1, -1);
        capture(9,   1'b0, -1, -1);
        capture(100, 1'b0, -1, -1);
        capture(0,   1'b1, -1, -1);
        capture(42,  1'b0, -1, -1);
        capture(123, 1'b0, 4, -1);      // pulse of 77 mid-conversion ignored
        capture(1,   1'b0, 7, -1);      // pulse on final conversion cycle ignored

        // Asynchronous reset in the middle of a conversion
        capture(200, 1'b0, -1, 3);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("arst_bcd", 32'(bcd_out), 32'd0);
        chk("arst_valid", 32'(bcd_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        shown = '0;
        capture(58, 1'b0, -1, -1);

        // Randomized captures, with random ignored pulses during conversion
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 255));
            e = !last_err && ($urandom_range(0, 4) == 0);
            capture(v, e, -2, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
